// File: rtl/leglite_pkg.sv
// Shared types and defaults for the leglite instruction-fetch slice.
// Holds the fetch FSM state encoding and the timer-width helper.
package leglite_pkg;

    localparam int INSTR_W       = 16;
    localparam int FETCH_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    // Wait counter is never narrower than 4 bits.
    function automatic int timer_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// Clearable saturating wait counter for the fetch request phase.
// expired flags that the next increment brings the count to LIMIT.
module fetch_timer
    import leglite_pkg::*;
#(
    parameter int LIMIT = FETCH_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = timer_width(LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CW'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= CW'(LIMIT - 1));

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues imem reads for pc and holds the result for decode.
// Flush drops in-flight or held instructions; misalignment or timeout is a sticky fault.
//
// state | meaning
// IDLE  | check pc alignment, latch request address
// REQ   | imem_req asserted, waiting for imem_ack
// HOLD  | instruction held for decode (instr_valid)
// FAULT | sticky error, left only by reset
module inst_fetch
    import leglite_pkg::*;
#(
    parameter int WIDTH   = INSTR_W,
    parameter int TIMEOUT = FETCH_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    output logic             pc_advance,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             fault
);

    fetch_state_t state, state_next;
    logic         discard, discard_next;
    logic         load_addr, load_instr;
    logic         timer_clear, timer_inc, timer_expired;

    fetch_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .inc     (timer_inc),
        .expired (timer_expired)
    );

    always_comb begin
        state_next   = state;
        discard_next = discard;
        load_addr    = 1'b0;
        load_instr   = 1'b0;
        timer_clear  = 1'b0;
        timer_inc    = 1'b0;
        pc_advance   = 1'b0;
        case (state)
            IDLE: begin
                if (pc[0]) begin
                    state_next = FAULT;
                end else begin
                    load_addr   = 1'b1;
                    timer_clear = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (discard || flush) begin
                        discard_next = 1'b0;
                        state_next   = IDLE;
                    end else begin
                        load_instr = 1'b1;
                        pc_advance = 1'b1;
                        state_next = HOLD;
                    end
                end else if (flush) begin
                    // Request stays up until acked; the late data is dropped.
                    discard_next = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                    if (timer_expired) begin
                        state_next = FAULT;
                    end
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    if (flush) begin
                        state_next = IDLE;
                    end else if (pc[0]) begin
                        state_next = FAULT;
                    end else begin
                        load_addr   = 1'b1;
                        timer_clear = 1'b1;
                        state_next  = REQ;
                    end
                end else if (flush) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            discard   <= 1'b0;
            imem_addr <= '0;
            instr     <= '0;
            instr_pc  <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
            if (load_addr) begin
                imem_addr <= pc;
            end
            if (load_instr) begin
                instr    <= imem_rdata;
                instr_pc <= imem_addr;
            end
        end
    end

    assign imem_req    = (state == REQ);
    assign instr_valid = (state == HOLD);
    assign fault       = (state == FAULT);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, fetch, back-to-back, flushes, timeout, misalignment.
module tb_inst_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] pc;
    logic        flush;
    logic        pc_advance;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fault;

    int checks = 0;
    int errors = 0;
    int n;

    inst_fetch #(.WIDTH(16), .TIMEOUT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .flush       (flush),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        step();
        step();
        check("rst_req",    32'(imem_req),    32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_fault",  32'(fault),       32'd0);
        check("rst_instr",  32'(instr),       32'd0);
        check("rst_ipc",    32'(instr_pc),    32'd0);
        check("rst_addr",   32'(imem_addr),   32'd0);
        check("rst_adv",    32'(pc_advance),  32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pc = '0; flush = 1'b0; imem_ack = 1'b0;
        imem_rdata = '0; instr_ready = 1'b0;

        // Reset then fetch with two wait cycles
        pc = 16'h0000;
        do_reset();
        settle();
        check("t1_idle_req", 32'(imem_req), 32'd0);
        step(); settle();
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", 32'(imem_addr), 32'h0000);
        check("t1_adv_wait", 32'(pc_advance), 32'd0);
        step(); settle();
        check("t1_req_w2", 32'(imem_req), 32'd1);
        step();
        imem_ack = 1'b1; imem_rdata = 16'h8A21; settle();
        check("t1_adv", 32'(pc_advance), 32'd1);
        step();
        imem_ack = 1'b0; imem_rdata = '0; pc = 16'h0002; settle();
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", 32'(instr), 32'h8A21);
        check("t1_ipc", 32'(instr_pc), 32'h0000);
        check("t1_adv_hold", 32'(pc_advance), 32'd0);
        step(); settle();
        check("t1_valid_held", 32'(instr_valid), 32'd1);
        check("t1_instr_held", 32'(instr), 32'h8A21);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0; settle();
        check("t1_valid_done", 32'(instr_valid), 32'd0);
        check("t1_next_req", 32'(imem_req), 32'd1);
        check("t1_next_addr", 32'(imem_addr), 32'h0002);

        // Back-to-back, same-cycle ack, decode always ready
        pc = 16'h0000;
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1; imem_rdata = 16'hA000 + 16'(i); instr_ready = 1'b1; settle();
            check("b2b_req", 32'(imem_req), 32'd1);
            check("b2b_addr", 32'(imem_addr), 32'(2 * i));
            check("b2b_adv", 32'(pc_advance), 32'd1);
            step();
            imem_ack = 1'b0; pc = 16'(2 * (i + 1)); settle();
            check("b2b_valid", 32'(instr_valid), 32'd1);
            check("b2b_ipc", 32'(instr_pc), 32'(2 * i));
            check("b2b_instr", 32'(instr), 32'hA000 + 32'(i));
            check("b2b_adv_hold", 32'(pc_advance), 32'd0);
            step();
        end
        instr_ready = 1'b0;

        // Flush while waiting in REQ
        pc = 16'h0010;
        do_reset();
        step(); settle();
        check("fr_addr", 32'(imem_addr), 32'h0010);
        step();
        flush = 1'b1; settle();
        check("fr_adv_flush", 32'(pc_advance), 32'd0);
        step();
        flush = 1'b0; pc = 16'h0040; settle();
        check("fr_req_kept", 32'(imem_req), 32'd1);
        step();
        step();
        imem_ack = 1'b1; imem_rdata = 16'hDEAD; settle();
        check("fr_adv_ack", 32'(pc_advance), 32'd0);
        check("fr_addr_stable", 32'(imem_addr), 32'h0010);
        step();
        imem_ack = 1'b0; settle();
        check("fr_no_valid", 32'(instr_valid), 32'd0);
        check("fr_idle", 32'(imem_req), 32'd0);
        step(); settle();
        check("fr_new_req", 32'(imem_req), 32'd1);
        check("fr_new_addr", 32'(imem_addr), 32'h0040);
        imem_ack = 1'b1; imem_rdata = 16'h1234; settle();
        check("fr_new_adv", 32'(pc_advance), 32'd1);
        step();
        imem_ack = 1'b0; pc = 16'h0042; settle();
        check("fr_new_instr", 32'(instr), 32'h1234);
        check("fr_new_ipc", 32'(instr_pc), 32'h0040);

        // Flush in HOLD without decode ready
        flush = 1'b1; settle();
        check("fh_valid_pre", 32'(instr_valid), 32'd1);
        step();
        flush = 1'b0; pc = 16'h0050; settle();
        check("fh_dropped", 32'(instr_valid), 32'd0);
        check("fh_idle", 32'(imem_req), 32'd0);
        step(); settle();
        check("fh_addr", 32'(imem_addr), 32'h0050);
        imem_ack = 1'b1; imem_rdata = 16'h5555;
        step();
        imem_ack = 1'b0; settle();
        check("fh_instr", 32'(instr), 32'h5555);
        // Flush together with ready: transfer completes, then IDLE
        instr_ready = 1'b1; flush = 1'b1;
        step();
        instr_ready = 1'b0; flush = 1'b0; pc = 16'h0060; settle();
        check("fhr_valid", 32'(instr_valid), 32'd0);
        check("fhr_idle", 32'(imem_req), 32'd0);
        step(); settle();
        check("fhr_req", 32'(imem_req), 32'd1);
        check("fhr_addr", 32'(imem_addr), 32'h0060);

        // Misaligned pc at the end of a transfer
        imem_ack = 1'b1; imem_rdata = 16'h7777;
        step();
        imem_ack = 1'b0; pc = 16'h0005; instr_ready = 1'b1;
        step();
        instr_ready = 1'b0; settle();
        check("mh_fault", 32'(fault), 32'd1);
        check("mh_req", 32'(imem_req), 32'd0);
        check("mh_addr", 32'(imem_addr), 32'h0060);

        // Timeout: no ack at all
        pc = 16'h0000;
        do_reset();
        step();
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("to_cycles", 32'(n), 32'd15);
        check("to_fault", 32'(fault), 32'd1);
        check("to_req", 32'(imem_req), 32'd0);
        repeat (5) step();
        imem_ack = 1'b1; settle();
        check("to_fault_sticky", 32'(fault), 32'd1);
        check("to_req_sticky", 32'(imem_req), 32'd0);
        check("to_adv", 32'(pc_advance), 32'd0);
        check("to_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;

        // Misaligned pc in IDLE
        pc = 16'h0003;
        do_reset();
        settle();
        check("mi_idle_req", 32'(imem_req), 32'd0);
        step(); settle();
        check("mi_fault", 32'(fault), 32'd1);
        check("mi_req", 32'(imem_req), 32'd0);
        check("mi_addr", 32'(imem_addr), 32'h0000);
        step(); settle();
        check("mi_fault_sticky", 32'(fault), 32'd1);
        pc = 16'h0008;
        do_reset();
        step(); settle();
        check("mi_recover_req", 32'(imem_req), 32'd1);
        check("mi_recover_addr", 32'(imem_addr), 32'h0008);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage that sits directly downstream of the program counter logic. Each cycle it may take the current `pc`, issue a read to instruction memory over a req/ack handshake, and hold the returned 16-bit instruction for decode under a valid/ready handshake. It pulses `pc_advance` once per accepted instruction so the PC steps exactly once per fetch. It also drops in-flight or held instructions on a taken-branch `flush`, and raises a sticky `fault` on a misaligned PC or a memory timeout.

## Interface
- `WIDTH`, 16: instruction and address width.
- `TIMEOUT`, 15: maximum cycles spent in REQ without `imem_ack` before fault; must be ≥1.
- `clock` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `pc` in WIDTH: current program counter.
- `flush` in 1: taken branch; PC is redirected at this edge, and `pc` is valid from the next cycle.
- `pc_advance` out 1: combinational; PC may step at this edge.
- `imem_req` out 1: read request.
- `imem_addr` out WIDTH: registered read address.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in WIDTH: read data.
- `instr` out WIDTH: held instruction.
- `instr_pc` out WIDTH: address of `instr`.
- `instr_valid` out 1: `instr` is valid.
- `instr_ready` in 1: decode accepts `instr`.
- `fault` out 1: sticky error.

## Operation
- The block has four states: IDLE, REQ, HOLD and FAULT.
- Reset values: state IDLE; `imem_addr`, `instr` and `instr_pc` are 0; `imem_req`, `instr_valid`, `fault` and the internal `discard` flag are 0; the timeout count is 0.
- **IDLE**
  - If `pc[0]`=1, go to FAULT.
  - Otherwise latch `imem_addr`←`pc`, clear the count, and go to REQ.
- **REQ**
  - `imem_req`=1 and `imem_addr` is stable.
  - Ack with neither `discard` nor `flush`: `instr`←`imem_rdata`, `instr_pc`←`imem_addr`, `pc_advance`=1 this cycle, go to HOLD.
  - Ack with `discard` or `flush`: drop the data, clear `discard`, go to IDLE. `pc_advance` stays 0.
  - No ack with `flush`: set `discard` and stay in REQ. The request is never withdrawn before ack.
  - No ack and no flush: increment the count. When the count reaches `TIMEOUT`, go to FAULT.
- **HOLD**
  - `instr_valid`=1; `instr` and `instr_pc` are stable.
  - `instr_ready`=1 completes the transfer:
    - without `flush`: latch `imem_addr`←`pc` (misaligned goes to FAULT), clear the count, go to REQ;
    - with `flush`: the transfer still counts, then go to IDLE.
  - `flush` without `instr_ready`: drop the instruction and go to IDLE.
- **FAULT**
  - `fault`=1, `imem_req`=0, `instr_valid`=0.
  - Exit only via `reset`.
- `pc_advance` = (state==REQ) & `imem_ack` & ~`discard` & ~`flush`. It is never asserted in any other state.
- `reset` takes priority over every event, including mid-request. Memory must tolerate a request abandoned by reset.

## Timing
- First request: `imem_req` rises in the 2nd cycle after `reset` is released (IDLE, then REQ).
- Fetch latency: the ack edge loads `instr`, and `instr_valid`=1 the next cycle.
- Throughput: with same-cycle ack and `instr_ready` held high, one instruction every 2 cycles (REQ, HOLD).
- Flush without ack in REQ costs the remaining wait, plus one IDLE cycle, plus the new request.
- The timeout count is 4 bits minimum, sized as clog2(`TIMEOUT`+1). Fault is entered on the edge where the wait count equals `TIMEOUT`.

## Structure
- Shared package `leglite_pkg` holds:
  - the state enum `fetch_state_t` (IDLE, REQ, HOLD, FAULT);
  - `INSTR_W`=16;
  - the default `FETCH_TIMEOUT`=15.
- Sub-module `fetch_timer`: a clearable saturating counter with an `expired` output.
- The FSM and datapath registers are in `inst_fetch`.

## Test plan
- **Reset then fetch:** `pc`=0x0000, ack after 2 wait cycles with rdata 0x8A21 → `instr`=0x8A21, `instr_pc`=0, one `pc_advance` pulse, and `instr_valid` held until `instr_ready`.
- **Back-to-back:** same-cycle ack, `instr_ready`=1, `pc` stepping by 2 → one instruction every 2 cycles, `instr_pc` sequence 0, 2, 4, 6.
- **Flush in REQ:** `flush` at wait cycle 1, ack 3 cycles later with 0xDEAD → no `instr_valid` and no `pc_advance`; the next request uses the new `pc` (0x0040).
- **Flush in HOLD:** with `instr_ready`=0 → `instr_valid` drops the next cycle. With `instr_ready`=1 → the transfer counts, then IDLE.
- **Timeout:** no ack for 15 cycles in REQ → `fault`=1 and `imem_req`=0; both persist until `reset`.
- **Misaligned:** `pc`=0x0003 at IDLE → FAULT with no request issued; `reset` then clears it.
